mpc_isu_arb: RTL and testbench
==============================

MPC_ISU_ARB -- requirements
Module: mpc_isu_arb

Interface
REQ-001 Parameter Cfg, default mpcBuildConfig(default mpc_user_cfg_t), cache geometry (clWidth 256, clWordWidth 128).
REQ-002 Parameter NumReq, default 3, number of requesters; the value is fixed at 3 to match the 3-bit one-hot channel id.
REQ-003 Type parameters robWidth_t, setWidth_t, wayIndexWidth_t, offsetWidth_t, wbufWidth_t, default logic vectors sized from Cfg, field types.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 req_valid  in  NumReq  per-requester request valid (0 = LSQ, 1 = refill, 2 = writeback).
REQ-007 req_ready  out  NumReq  per-requester accept.
REQ-008 req_rob_id  in  NumReq x robWidth_t  ROB tag.
REQ-009 req_op  in  NumReq x 3  cache op code (mpc_types CACHE_OP_*).
REQ-010 req_set / req_way / req_offset  in  NumReq x setWidth_t / wayIndexWidth_t / offsetWidth_t  bank address.
REQ-011 req_wbuf_id  in  NumReq x wbufWidth_t  write-buffer slot.
REQ-012 req_refill_data  in  NumReq x 256  refill line data.
REQ-013 u_isu_valid  out  1  issue request to the bank wrapper.
REQ-014 u_isu_ready  in  1  bank wrapper accepts.
REQ-015 u_isu_channel_1hot_id  out  3  one-hot id of the granted requester.
REQ-016 u_isu_rob_id, u_isu_op, u_isu_set, u_isu_way, u_isu_offset, u_isu_wbuf_id, u_isu_refill_data  out  same widths  registered payload.
REQ-017 lock_err  out  1  one-cycle pulse on a burst protocol violation.

Function
REQ-018 One output register; a beat is accepted when req_valid[i] && req_ready[i], and appears on u_isu_* the next cycle (latency 1).
REQ-019 req_ready[i] = grant[i] && (!u_isu_valid || u_isu_ready); this gives full throughput of one beat per cycle and no bubble on back-to-back accepts.
REQ-020 While u_isu_valid && !u_isu_ready, the payload and channel id are held stable.
REQ-021 Round-robin arbitration: a priority pointer rr_ptr (2 bits, values 0..2, wraps 2->0); grant goes to the first valid requester at or after rr_ptr.
REQ-022 After an accepted non-burst beat or final burst beat from requester i, rr_ptr becomes (i+1) mod 3; otherwise rr_ptr is unchanged.
REQ-023 Burst ops are CACHE_OP_LOAD_REFILL, CACHE_OP_STORE_REFILL and CACHE_OP_WB; each is two beats, offset 0 then offset 1.
REQ-024 FSM states: IDLE (no lock) and LOCK (owner register, 2 bits).
REQ-025 IDLE->LOCK on an accepted burst beat with offset 0; the owner is set to that requester.
REQ-026 LOCK->IDLE on an accepted offset-1 beat from the owner.
REQ-027 In LOCK, only the owner can be granted; all other req_ready are 0, even if the owner drops req_valid; there is no timeout.
REQ-028 In LOCK, an accepted owner beat with a non-burst op or offset 0 is still forwarded, pulses lock_err the next cycle, and keeps the lock.
REQ-029 An offset-1 burst beat accepted in IDLE is forwarded as a single beat and pulses lock_err.
REQ-030 If no requester is valid, no grant is issued; u_isu_valid falls after the held beat drains.
REQ-031 u_isu_channel_1hot_id = 1 << granted index (001, 010 or 100).

Reset
REQ-032 With rst_n low at a clock edge: u_isu_valid=0, every u_isu_* payload=0, lock_err=0, rst_n-state IDLE, rr_ptr=0, owner=0, req_ready=0.
REQ-033 Reset asserted mid-burst or mid-stall drops the held beat and the lock, with no drain; the first grant after reset follows rr_ptr=0.

Structure
REQ-034 CACHE_OP_* codes, a helper classifying an op as a burst op, and NumReq belong in mpc_types; no new package.
REQ-035 One sub-module, mpc_rr_arb (generic round-robin pick with pointer and lock-mask input); the FSM and output register live in the top.

Verification
REQ-036 Requesters 0, 1 and 2 all valid with single-beat CACHE_OP_LOAD, u_isu_ready=1 -> grants 0, 1, 2, 0 on consecutive cycles; u_isu_channel_1hot_id 001, 010, 100, 001.
REQ-037 Requester 1 LOAD_REFILL offset 0 then offset 1 (data 'haaaa_bbbb_cccc_dddd), requester 0 valid throughout -> requester 0 has req_ready=0 until the offset-1 beat is accepted, then is granted next.
REQ-038 u_isu_ready=0 for 4 cycles with requester 2 holding a CACHE_OP_WB beat -> payload stable, req_ready=0; one cycle after ready rises, the next beat is issued.
REQ-039 Owner 2 in LOCK sends CACHE_OP_STORE offset 0 -> beat forwarded, lock_err=1 for one cycle, lock retained.
REQ-040 rst_n low for 1 cycle between a STORE_REFILL offset-0 and offset-1 beat -> u_isu_valid=0 next cycle, IDLE, requester 0 granted first.

Source files
------------

// File: rtl/mpc_types.sv
// rtl/mpc_types.sv - shared cache geometry, cache op codes and requester count
package mpc_types;

    // User-facing knobs; everything else is derived by mpcBuildConfig.
    typedef struct packed {
        int unsigned numSets;
        int unsigned numWays;
        int unsigned robEntries;
        int unsigned wbufEntries;
        int unsigned clWidth;
        int unsigned clWordWidth;
    } mpc_user_cfg_t;

    // Derived geometry consumed by the cache pipeline blocks.
    typedef struct packed {
        int unsigned clWidth;
        int unsigned clWordWidth;
        int unsigned robWidth;
        int unsigned setWidth;
        int unsigned wayIndexWidth;
        int unsigned offsetWidth;
        int unsigned wbufWidth;
    } mpc_cfg_t;

    localparam mpc_user_cfg_t MPC_DEFAULT_USER_CFG = '{
        numSets:     64,
        numWays:     4,
        robEntries:  32,
        wbufEntries: 8,
        clWidth:     256,
        clWordWidth: 128
    };

    // Number of issue requesters: LSQ, refill, writeback.
    localparam int unsigned MPC_NUM_REQ = 3;

    localparam logic [2:0] CACHE_OP_LOAD         = 3'd0;
    localparam logic [2:0] CACHE_OP_STORE        = 3'd1;
    localparam logic [2:0] CACHE_OP_LOAD_REFILL  = 3'd2;
    localparam logic [2:0] CACHE_OP_STORE_REFILL = 3'd3;
    localparam logic [2:0] CACHE_OP_WB           = 3'd4;

    // Index width that never collapses to zero bits.
    function automatic int unsigned mpc_clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    function automatic mpc_cfg_t mpcBuildConfig(input mpc_user_cfg_t u);
        return '{
            clWidth:       u.clWidth,
            clWordWidth:   u.clWordWidth,
            robWidth:      mpc_clog2_min1(u.robEntries),
            setWidth:      mpc_clog2_min1(u.numSets),
            wayIndexWidth: mpc_clog2_min1(u.numWays),
            offsetWidth:   mpc_clog2_min1(u.clWidth / u.clWordWidth),
            wbufWidth:     mpc_clog2_min1(u.wbufEntries)
        };
    endfunction

    // Line-sized ops move a full cache line as two word beats.
    function automatic logic is_burst_op(input logic [2:0] op);
        return (op == CACHE_OP_LOAD_REFILL) || (op == CACHE_OP_STORE_REFILL) ||
               (op == CACHE_OP_WB);
    endfunction

endpackage

// File: rtl/mpc_rr_arb.sv
// rtl/mpc_rr_arb.sv - round-robin pick with priority pointer and single-owner lock mask
//   valid      in  N     request lines
//   ptr        in  PtrW  highest-priority index this cycle
//   lock_en    in  1     restrict the pick to lock_owner
//   lock_owner in  PtrW  only requester eligible while lock_en
//   grant      out N     one-hot grant (zero when nothing eligible)
//   grant_idx  out PtrW  binary index of grant
//   grant_any  out 1     a grant was issued
module mpc_rr_arb #(
    parameter int unsigned N    = 3,
    parameter int unsigned PtrW = 2
) (
    input  logic [N-1:0]    valid,
    input  logic [PtrW-1:0] ptr,
    input  logic            lock_en,
    input  logic [PtrW-1:0] lock_owner,
    output logic [N-1:0]    grant,
    output logic [PtrW-1:0] grant_idx,
    output logic            grant_any
);

    logic [N-1:0]    eligible;
    logic [PtrW-1:0] cand;

    always_comb begin
        eligible  = lock_en ? (valid & (N'(1) << lock_owner)) : valid;
        cand      = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        // Walk from ptr upward with wrap; first eligible requester wins.
        for (int unsigned k = 0; k < N; k++) begin
            cand = PtrW'((32'(ptr) + k) % N);
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        grant = grant_any ? (N'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/mpc_isu_arb.sv
// rtl/mpc_isu_arb.sv - issue arbiter: round-robin over LSQ/refill/writeback with burst lock
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid/req_ready         per-requester handshake (0 LSQ, 1 refill, 2 writeback)
//   req_rob_id..req_refill_data per-requester beat payload
//   u_isu_valid/u_isu_ready     registered issue handshake towards the bank wrapper
//   u_isu_channel_1hot_id       one-hot id of the requester that owns the issued beat
//   u_isu_rob_id..refill_data   registered issued payload
//   lock_err                    one-cycle pulse on a burst protocol violation
module mpc_isu_arb
    import mpc_types::*;
#(
    parameter mpc_cfg_t    Cfg             = mpcBuildConfig(MPC_DEFAULT_USER_CFG),
    parameter int unsigned NumReq          = MPC_NUM_REQ,
    parameter type         robWidth_t      = logic [Cfg.robWidth-1:0],
    parameter type         setWidth_t      = logic [Cfg.setWidth-1:0],
    parameter type         wayIndexWidth_t = logic [Cfg.wayIndexWidth-1:0],
    parameter type         offsetWidth_t   = logic [Cfg.offsetWidth-1:0],
    parameter type         wbufWidth_t     = logic [Cfg.wbufWidth-1:0]
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NumReq-1:0]      req_valid,
    output logic [NumReq-1:0]      req_ready,
    input  robWidth_t              req_rob_id      [NumReq],
    input  logic [2:0]             req_op          [NumReq],
    input  setWidth_t              req_set         [NumReq],
    input  wayIndexWidth_t         req_way         [NumReq],
    input  offsetWidth_t           req_offset      [NumReq],
    input  wbufWidth_t             req_wbuf_id     [NumReq],
    input  logic [Cfg.clWidth-1:0] req_refill_data [NumReq],
    output logic                   u_isu_valid,
    input  logic                   u_isu_ready,
    output logic [NumReq-1:0]      u_isu_channel_1hot_id,
    output robWidth_t              u_isu_rob_id,
    output logic [2:0]             u_isu_op,
    output setWidth_t              u_isu_set,
    output wayIndexWidth_t         u_isu_way,
    output offsetWidth_t           u_isu_offset,
    output wbufWidth_t             u_isu_wbuf_id,
    output logic [Cfg.clWidth-1:0] u_isu_refill_data,
    output logic                   lock_err
);

    localparam int unsigned IdxW = 2;

    typedef enum logic {
        ST_IDLE,
        ST_LOCK
    } state_e;

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        owner_q, owner_d;
    logic [IdxW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                   isu_valid_q, isu_valid_d;
    logic [NumReq-1:0]      chan_q, chan_d;
    robWidth_t              rob_q, rob_d;
    logic [2:0]             op_q, op_d;
    setWidth_t              set_q, set_d;
    wayIndexWidth_t         way_q, way_d;
    offsetWidth_t           offset_q, offset_d;
    wbufWidth_t             wbuf_q, wbuf_d;
    logic [Cfg.clWidth-1:0] data_q, data_d;
    logic                   lock_err_q, lock_err_d;

    logic [NumReq-1:0]      grant;
    logic [IdxW-1:0]        grant_idx;
    logic                   grant_any;
    logic                   out_free;
    logic                   accept;
    logic                   acc_burst;
    logic                   acc_first;
    logic                   acc_last;

    mpc_rr_arb #(
        .N    (NumReq),
        .PtrW (IdxW)
    ) u_rr_arb (
        .valid      (req_valid),
        .ptr        (rr_ptr_q),
        .lock_en    (state_q == ST_LOCK),
        .lock_owner (owner_q),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    // The output register can take a new beat when empty or draining this cycle.
    assign out_free  = !isu_valid_q || u_isu_ready;
    assign req_ready = grant & {NumReq{out_free && rst_n}};
    assign accept    = grant_any && out_free && rst_n;

    assign acc_burst = is_burst_op(req_op[grant_idx]);
    assign acc_first = (req_offset[grant_idx] == offsetWidth_t'(0));
    assign acc_last  = (req_offset[grant_idx] == offsetWidth_t'(1));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        isu_valid_d = isu_valid_q;
        chan_d      = chan_q;
        rob_d       = rob_q;
        op_d        = op_q;
        set_d       = set_q;
        way_d       = way_q;
        offset_d    = offset_q;
        wbuf_d      = wbuf_q;
        data_d      = data_q;
        lock_err_d  = 1'b0;

        if (accept) begin
            isu_valid_d = 1'b1;
            chan_d      = NumReq'(1) << grant_idx;
            rob_d       = req_rob_id[grant_idx];
            op_d        = req_op[grant_idx];
            set_d       = req_set[grant_idx];
            way_d       = req_way[grant_idx];
            offset_d    = req_offset[grant_idx];
            wbuf_d      = req_wbuf_id[grant_idx];
            data_d      = req_refill_data[grant_idx];

            case (state_q)
                ST_IDLE: begin
                    if (acc_burst && acc_first) begin
                        state_d = ST_LOCK;
                        owner_d = grant_idx;
                    end else if (acc_burst) begin
                        // A second beat with no opening beat: forwarded alone.
                        lock_err_d = 1'b1;
                    end
                end
                ST_LOCK: begin
                    // Only the owner can be accepted here.
                    if (acc_burst && acc_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        lock_err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Priority moves on only once the requester's transfer is complete.
            if (state_d == ST_IDLE) begin
                rr_ptr_d = (grant_idx == IdxW'(NumReq - 1)) ? '0 : grant_idx + 1'b1;
            end
        end else if (u_isu_ready) begin
            isu_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            isu_valid_q <= 1'b0;
            chan_q      <= '0;
            rob_q       <= '0;
            op_q        <= '0;
            set_q       <= '0;
            way_q       <= '0;
            offset_q    <= '0;
            wbuf_q      <= '0;
            data_q      <= '0;
            lock_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            isu_valid_q <= isu_valid_d;
            chan_q      <= chan_d;
            rob_q       <= rob_d;
            op_q        <= op_d;
            set_q       <= set_d;
            way_q       <= way_d;
            offset_q    <= offset_d;
            wbuf_q      <= wbuf_d;
            data_q      <= data_d;
            lock_err_q  <= lock_err_d;
        end
    end

    assign u_isu_valid           = isu_valid_q;
    assign u_isu_channel_1hot_id = chan_q;
    assign u_isu_rob_id          = rob_q;
    assign u_isu_op              = op_q;
    assign u_isu_set             = set_q;
    assign u_isu_way             = way_q;
    assign u_isu_offset          = offset_q;
    assign u_isu_wbuf_id         = wbuf_q;
    assign u_isu_refill_data     = data_q;
    assign lock_err              = lock_err_q;

endmodule

// File: tb/tb_mpc_isu_arb.sv
// tb/tb_mpc_isu_arb.sv - directed vector bench for mpc_isu_arb
module tb_mpc_isu_arb;
    import mpc_types::*;

    localparam mpc_cfg_t C = mpcBuildConfig(MPC_DEFAULT_USER_CFG);

    localparam logic [2:0] LD = CACHE_OP_LOAD;
    localparam logic [2:0] ST = CACHE_OP_STORE;
    localparam logic [2:0] LR = CACHE_OP_LOAD_REFILL;
    localparam logic [2:0] SR = CACHE_OP_STORE_REFILL;
    localparam logic [2:0] WB = CACHE_OP_WB;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [2:0]               req_valid;
    logic [2:0]               req_ready;
    logic [C.robWidth-1:0]    req_rob_id      [3];
    logic [2:0]               req_op          [3];
    logic [C.setWidth-1:0]    req_set         [3];
    logic [C.wayIndexWidth-1:0] req_way       [3];
    logic [C.offsetWidth-1:0] req_offset      [3];
    logic [C.wbufWidth-1:0]   req_wbuf_id     [3];
    logic [C.clWidth-1:0]     req_refill_data [3];
    logic                     u_isu_valid;
    logic                     u_isu_ready;
    logic [2:0]               u_isu_channel_1hot_id;
    logic [C.robWidth-1:0]    u_isu_rob_id;
    logic [2:0]               u_isu_op;
    logic [C.setWidth-1:0]    u_isu_set;
    logic [C.wayIndexWidth-1:0] u_isu_way;
    logic [C.offsetWidth-1:0] u_isu_offset;
    logic [C.wbufWidth-1:0]   u_isu_wbuf_id;
    logic [C.clWidth-1:0]     u_isu_refill_data;
    logic                     lock_err;

    mpc_isu_arb dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_rob_id            (req_rob_id),
        .req_op                (req_op),
        .req_set               (req_set),
        .req_way               (req_way),
        .req_offset            (req_offset),
        .req_wbuf_id           (req_wbuf_id),
        .req_refill_data       (req_refill_data),
        .u_isu_valid           (u_isu_valid),
        .u_isu_ready           (u_isu_ready),
        .u_isu_channel_1hot_id (u_isu_channel_1hot_id),
        .u_isu_rob_id          (u_isu_rob_id),
        .u_isu_op              (u_isu_op),
        .u_isu_set             (u_isu_set),
        .u_isu_way             (u_isu_way),
        .u_isu_offset          (u_isu_offset),
        .u_isu_wbuf_id         (u_isu_wbuf_id),
        .u_isu_refill_data     (u_isu_refill_data),
        .lock_err              (lock_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic [2:0] vld;
        logic [2:0] op0, op1, op2;
        logic [2:0] off;
        logic       rdy;
        logic [2:0] e_rdy;
        logic       e_v;
        logic [2:0] e_ch;
        logic       e_off;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [63:0] DATA0 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] DATA1 = 64'haaaa_bbbb_cccc_dddd;
    localparam logic [63:0] DATA2 = 64'h5555_6666_7777_8888;

    task automatic add(input string n, input logic r, input logic [2:0] v,
                       input logic [2:0] o0, input logic [2:0] o1, input logic [2:0] o2,
                       input logic [2:0] of, input logic rd, input logic [2:0] er,
                       input logic ev, input logic [2:0] ec, input logic eo, input logic ee);
        vec_t t;
        t.name = n; t.rst = r; t.vld = v; t.op0 = o0; t.op1 = o1; t.op2 = o2;
        t.off = of; t.rdy = rd; t.e_rdy = er; t.e_v = ev; t.e_ch = ec;
        t.e_off = eo; t.e_err = ee;
        tbl.push_back(t);
    endtask

    task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", n, act, exp);
        end
    endtask

    // Requester payloads are fixed, so the issued payload follows from the channel.
    function automatic logic [C.robWidth-1:0] exp_rob(input logic [2:0] ch);
        case (ch)
            3'b001:  return 5'd10;
            3'b010:  return 5'd11;
            3'b100:  return 5'd12;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [255:0] exp_data(input logic [2:0] ch);
        case (ch)
            3'b001:  return {192'd0, DATA0};
            3'b010:  return {192'd0, DATA1};
            3'b100:  return {192'd0, DATA2};
            default: return '0;
        endcase
    endfunction

    task automatic drive(input logic r, input logic [2:0] v, input logic [2:0] o0,
                         input logic [2:0] o1, input logic [2:0] o2, input logic [2:0] of,
                         input logic rd);
        rst_n       = r;
        req_valid   = v;
        req_op[0]   = o0;
        req_op[1]   = o1;
        req_op[2]   = o2;
        req_offset[0] = of[0];
        req_offset[1] = of[1];
        req_offset[2] = of[2];
        u_isu_ready = rd;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            req_rob_id[i]  = 5'(10 + i);
            req_set[i]     = 6'(i + 1);
            req_way[i]     = 2'(i);
            req_wbuf_id[i] = 3'(i + 4);
        end
        req_refill_data[0] = {192'd0, DATA0};
        req_refill_data[1] = {192'd0, DATA1};
        req_refill_data[2] = {192'd0, DATA2};

        // name, rst, vld, op0, op1, op2, off, rdy | e_rdy, e_v, e_ch, e_off, e_err
        add("rst_state",  1, 3'b000, LD, LD, LD, 3'b000, 1, 3'b000, 0, 3'b000, 0, 0);
        add("rr_g0",      1, 3'b111, LD, LD, LD, 3'b000, 1, 3'b001, 0, 3'b000, 0, 0);
        add("rr_g1",      1, 3'b111, LD, LD, LD, 3'b000, 1, 3'b010, 1, 3'b001, 0, 0);
        add("rr_g2",      1, 3'b111, LD, LD, LD, 3'b000, 1, 3'b100, 1, 3'b010, 0, 0);
        add("rr_g0b",     1, 3'b111, LD, LD, LD, 3'b000, 1, 3'b001, 1, 3'b100, 0, 0);
        add("rr_drain",   1, 3'b000, LD, LD, LD, 3'b000, 1, 3'b000, 1, 3'b001, 0, 0);
        add("rr_idle",    1, 3'b000, LD, LD, LD, 3'b000, 1, 3'b000, 0, 3'b001, 0, 0);
        add("lr_first",   1, 3'b011, LD, LR, LD, 3'b000, 1, 3'b010, 0, 3'b001, 0, 0);
        add("lock_drop",  1, 3'b001, LD, LR, LD, 3'b010, 1, 3'b000, 1, 3'b010, 0, 0);
        add("lr_last",    1, 3'b011, LD, LR, LD, 3'b010, 1, 3'b010, 0, 3'b010, 0, 0);
        add("post_lock",  1, 3'b001, LD, LR, LD, 3'b000, 1, 3'b001, 1, 3'b010, 1, 0);
        add("idle2",      1, 3'b000, LD, LD, LD, 3'b000, 1, 3'b000, 1, 3'b001, 0, 0);
        add("wb_first",   1, 3'b100, LD, LD, WB, 3'b000, 1, 3'b100, 0, 3'b001, 0, 0);
        for (int i = 0; i < 4; i++)
            add("stall",  1, 3'b100, LD, LD, WB, 3'b100, 0, 3'b000, 1, 3'b100, 0, 0);
        add("stall_rel",  1, 3'b100, LD, LD, WB, 3'b100, 1, 3'b100, 1, 3'b100, 0, 0);
        add("wb_out",     1, 3'b000, LD, LD, WB, 3'b000, 1, 3'b000, 1, 3'b100, 1, 0);
        add("idle3",      1, 3'b000, LD, LD, LD, 3'b000, 1, 3'b000, 0, 3'b100, 1, 0);
        add("sr_first",   1, 3'b100, LD, LD, SR, 3'b000, 1, 3'b100, 0, 3'b100, 1, 0);
        add("bad_st",     1, 3'b101, LD, LD, ST, 3'b000, 1, 3'b100, 1, 3'b100, 0, 0);
        add("err_pulse",  1, 3'b101, LD, LD, SR, 3'b100, 1, 3'b100, 1, 3'b100, 0, 1);
        add("err_clear",  1, 3'b001, LD, LD, LD, 3'b000, 1, 3'b001, 1, 3'b100, 1, 0);
        add("idle4",      1, 3'b000, LD, LD, LD, 3'b000, 1, 3'b000, 1, 3'b001, 0, 0);
        add("stray_off1", 1, 3'b010, LD, LR, LD, 3'b010, 1, 3'b010, 0, 3'b001, 0, 0);
        add("stray_err",  1, 3'b001, LD, LD, LD, 3'b000, 1, 3'b001, 1, 3'b010, 1, 1);
        add("idle5",      1, 3'b000, LD, LD, LD, 3'b000, 1, 3'b000, 1, 3'b001, 0, 0);
        add("sr_start",   1, 3'b011, LD, SR, LD, 3'b000, 1, 3'b010, 0, 3'b001, 0, 0);
        add("mid_reset",  0, 3'b011, LD, SR, LD, 3'b010, 1, 3'b000, 1, 3'b010, 0, 0);
        add("post_reset", 1, 3'b011, LD, SR, LD, 3'b010, 1, 3'b001, 0, 3'b000, 0, 0);
        add("idle6",      1, 3'b000, LD, LD, LD, 3'b000, 1, 3'b000, 1, 3'b001, 0, 0);

        drive(0, 3'b000, LD, LD, LD, 3'b000, 1);
        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].vld, tbl[i].op0, tbl[i].op1, tbl[i].op2,
                  tbl[i].off, tbl[i].rdy);
            #1;
            chk({tbl[i].name, ".req_ready"}, 256'(req_ready), 256'(tbl[i].e_rdy));
            chk({tbl[i].name, ".valid"}, 256'(u_isu_valid), 256'(tbl[i].e_v));
            chk({tbl[i].name, ".chan"}, 256'(u_isu_channel_1hot_id), 256'(tbl[i].e_ch));
            chk({tbl[i].name, ".offset"}, 256'(u_isu_offset), 256'(tbl[i].e_off));
            chk({tbl[i].name, ".lock_err"}, 256'(lock_err), 256'(tbl[i].e_err));
            chk({tbl[i].name, ".rob_id"}, 256'(u_isu_rob_id), 256'(exp_rob(tbl[i].e_ch)));
            chk({tbl[i].name, ".data"}, u_isu_refill_data, exp_data(tbl[i].e_ch));
        end

        // Reset while a beat is stalled in the output register drops it.
        @(negedge clk);
        drive(1, 3'b001, LD, LD, LD, 3'b000, 0);
        #1;
        chk("stall_rst.accept", 256'(req_ready), 256'(3'b001));
        @(negedge clk);
        #1;
        chk("stall_rst.held_valid", 256'(u_isu_valid), 256'(1'b1));
        chk("stall_rst.held_chan", 256'(u_isu_channel_1hot_id), 256'(3'b001));
        chk("stall_rst.blocked", 256'(req_ready), 256'(3'b000));
        @(negedge clk);
        drive(0, 3'b001, LD, LD, LD, 3'b000, 0);
        #1;
        chk("stall_rst.rst_ready", 256'(req_ready), 256'(3'b000));
        @(negedge clk);
        drive(1, 3'b000, LD, LD, LD, 3'b000, 0);
        #1;
        chk("stall_rst.valid", 256'(u_isu_valid), 256'(1'b0));
        chk("stall_rst.chan", 256'(u_isu_channel_1hot_id), 256'(3'b000));
        chk("stall_rst.data", u_isu_refill_data, 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
